// File: rtl/cnn_sched_pkg.sv
// -----------------------------------------------------------------------------
// cnn_sched_pkg
// Shared definitions for the CNN layer scheduler:
//   - FSM state encoding
//   - layer descriptor word width
//   - descriptor field bit positions and widths
// No ports (package).
// -----------------------------------------------------------------------------
package cnn_sched_pkg;

    localparam int DESC_W     = 32;

    // Descriptor word layout (LSB positions and widths)
    localparam int FOLD_LSB   = 0;
    localparam int FOLD_W     = 4;
    localparam int POOLC_LSB  = 4;
    localparam int POOLC_W    = 4;
    localparam int STEP_LSB   = 8;
    localparam int STEP_W     = 3;
    localparam int LASTP_LSB  = 11;
    localparam int LASTP_W    = 4;
    localparam int POOLEN_BIT = 15;
    localparam int TILES_LSB  = 16;
    localparam int TILES_W    = 8;
    localparam int LAST_BIT   = 24;
    localparam int RSVD_LSB   = 25;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_CFG   = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_LEND  = 3'd5,
        ST_DONE  = 3'd6
    } sched_state_t;

endpackage

// File: rtl/cnn_layer_cfg_ram.sv
// -----------------------------------------------------------------------------
// cnn_layer_cfg_ram
// NUM_LAYERS x DESC_W layer descriptor table. One synchronous write port and
// one synchronous (registered) read port; contents are not reset.
// Ports:
//   clk       - clock
//   i_we      - write strobe
//   i_waddr   - write index
//   i_wdata   - descriptor word to write
//   i_raddr   - read index
//   o_rdata   - descriptor at i_raddr, one cycle after the address
// -----------------------------------------------------------------------------
module cnn_layer_cfg_ram
    import cnn_sched_pkg::*;
#(
    parameter int NUM_LAYERS = 8,
    parameter int LAYER_AW   = 3
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [LAYER_AW-1:0] i_waddr,
    input  logic [DESC_W-1:0]   i_wdata,
    input  logic [LAYER_AW-1:0] i_raddr,
    output logic [DESC_W-1:0]   o_rdata
);

    logic [DESC_W-1:0] r_mem [NUM_LAYERS];
    logic [DESC_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cnn_layer_sched.sv
// -----------------------------------------------------------------------------
// cnn_layer_sched
// Layer-level scheduler for the systolic-array CNN accelerator. Walks a table
// of per-layer descriptors, drives the static per-layer configuration of the
// output-address controller, issues compute tiles with a start/done handshake
// and produces the per-activation pooling phase qualifier.
//
// Optional feature macro: SCHED_PERF_CNT_EN
//   defined   -> adds output perf_cycles[31:0], busy-cycle counter that clears
//                on an accepted start, holds in IDLE and saturates.
//   undefined -> port and counter absent.
//
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   start                - pulse, begin a run from layer 0 (IDLE only)
//   abort                - synchronous return to IDLE, highest priority
//   cfg_we/waddr/wdata   - descriptor table write (accepted in IDLE only)
//   tile_start           - one-cycle compute-tile request
//   tile_done            - compute-tile completion pulse
//   acti_finish_flag     - activation result valid pulse
//   pooling_signal       - registered pooling phase for the next activation
//   fold_per_cols_in, pooling_cols, pool_win_per_period, pool_win_last_period
//                        - registered layer configuration
//   layer_idx            - current layer
//   busy                 - high outside IDLE
//   layer_done, net_done - end-of-layer / end-of-run pulses
//   cfg_err              - sticky: descriptor write attempted while busy
// -----------------------------------------------------------------------------
module cnn_layer_sched
    import cnn_sched_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int NUM_LAYERS = 8,
    parameter int LAYER_AW   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                cfg_we,
    input  logic [LAYER_AW-1:0] cfg_waddr,
    input  logic [31:0]         cfg_wdata,
    output logic                tile_start,
    input  logic                tile_done,
    input  logic                acti_finish_flag,
    output logic                pooling_signal,
    output logic [3:0]          fold_per_cols_in,
    output logic [3:0]          pooling_cols,
    output logic [2:0]          pool_win_per_period,
    output logic [3:0]          pool_win_last_period,
    output logic [LAYER_AW-1:0] layer_idx,
    output logic                busy,
    output logic                layer_done,
    output logic                net_done,
    output logic                cfg_err
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]         perf_cycles
`endif
);

    localparam logic [LAYER_AW-1:0] LAST_IDX = LAYER_AW'(NUM_LAYERS - 1);

    sched_state_t          r_state;
    sched_state_t          w_state_next;

    logic [DESC_W-1:0]     w_rdata;
    logic                  w_ram_we;
    logic                  w_start_ok;

    logic [FOLD_W-1:0]     r_fold;
    logic [POOLC_W-1:0]    r_poolc;
    logic [STEP_W-1:0]     r_win_step;
    logic [LASTP_W-1:0]    r_lastp;
    logic                  r_pool_en;
    logic                  r_last_layer;
    logic [TILES_W-1:0]    r_tile_cnt;
    logic [LAYER_AW-1:0]   r_layer_idx;
    logic                  r_cfg_err;
    logic [STEP_W-1:0]     r_wc;
    logic                  r_pool_sig;

    logic                  w_pool_active;
    logic [STEP_W-1:0]     w_step_last;
    logic [STEP_W-1:0]     w_wc_inc;

    // Reserved descriptor bits and the informational array geometry are
    // carried but not consumed by this block.
    logic [DESC_W-RSVD_LSB-1:0] w_unused_rsvd;
    logic [31:0]                w_unused_geom;
    assign w_unused_rsvd = w_rdata[DESC_W-1:RSVD_LSB];
    assign w_unused_geom = 32'(ROWS * COLS);

    assign w_start_ok = (r_state == ST_IDLE) && start && !abort;
    assign w_ram_we   = (r_state == ST_IDLE) && cfg_we;

    cnn_layer_cfg_ram #(
        .NUM_LAYERS (NUM_LAYERS),
        .LAYER_AW   (LAYER_AW)
    ) u_cfg_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (cfg_waddr),
        .i_wdata (cfg_wdata),
        .i_raddr (r_layer_idx),
        .o_rdata (w_rdata)
    );

    // A window of 0 or 1 activations has no accumulate phase.
    assign w_pool_active = r_pool_en && (r_win_step > 3'd1);
    assign w_step_last   = r_win_step - 3'd1;
    assign w_wc_inc      = (r_wc == w_step_last) ? '0 : r_wc + 3'd1;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (start) w_state_next = ST_FETCH;
                ST_FETCH: w_state_next = ST_CFG;
                ST_CFG:   w_state_next = (w_rdata[TILES_LSB +: TILES_W] == '0) ? ST_LEND : ST_ISSUE;
                ST_ISSUE: w_state_next = ST_WAIT;
                ST_WAIT: begin
                    if (tile_done) begin
                        w_state_next = (r_tile_cnt == 8'd1) ? ST_LEND : ST_ISSUE;
                    end
                end
                ST_LEND:  w_state_next = (r_last_layer || (r_layer_idx == LAST_IDX)) ? ST_DONE : ST_FETCH;
                ST_DONE:  w_state_next = ST_IDLE;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        tile_start = 1'b0;
        layer_done = 1'b0;
        net_done   = 1'b0;
        busy       = 1'b1;
        case (r_state)
            ST_IDLE:  busy       = 1'b0;
            ST_ISSUE: tile_start = 1'b1;
            ST_LEND:  layer_done = 1'b1;
            ST_DONE:  net_done   = 1'b1;
            default:  ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fold       <= '0;
            r_poolc      <= '0;
            r_win_step   <= '0;
            r_lastp      <= '0;
            r_pool_en    <= 1'b0;
            r_last_layer <= 1'b0;
            r_tile_cnt   <= '0;
            r_layer_idx  <= '0;
            r_cfg_err    <= 1'b0;
            r_wc         <= '0;
            r_pool_sig   <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_layer_idx <= '0;
            end else if (r_state == ST_LEND && w_state_next == ST_FETCH) begin
                r_layer_idx <= r_layer_idx + 1'b1;
            end

            // Start and busy writes are mutually exclusive (IDLE vs not).
            if (w_start_ok) begin
                r_cfg_err <= 1'b0;
            end else if (cfg_we && r_state != ST_IDLE) begin
                r_cfg_err <= 1'b1;
            end

            if (r_state == ST_CFG && !abort) begin
                r_fold       <= w_rdata[FOLD_LSB  +: FOLD_W];
                r_poolc      <= w_rdata[POOLC_LSB +: POOLC_W];
                r_win_step   <= w_rdata[STEP_LSB  +: STEP_W];
                r_lastp      <= w_rdata[LASTP_LSB +: LASTP_W];
                r_pool_en    <= w_rdata[POOLEN_BIT];
                r_last_layer <= w_rdata[LAST_BIT];
                r_tile_cnt   <= w_rdata[TILES_LSB +: TILES_W];
            end else if (r_state == ST_WAIT && tile_done && !abort) begin
                r_tile_cnt <= r_tile_cnt - 8'd1;
            end

            // pooling_signal always describes the phase of the NEXT
            // activation, so it is recomputed from the post-pulse count.
            if (abort) begin
                r_pool_sig <= 1'b0;
            end else begin
                case (r_state)
                    ST_ISSUE: begin
                        r_wc       <= '0;
                        r_pool_sig <= w_pool_active;
                    end
                    ST_WAIT: begin
                        if (acti_finish_flag && w_pool_active) begin
                            r_wc       <= w_wc_inc;
                            r_pool_sig <= (w_wc_inc != w_step_last);
                        end
                    end
                    default: r_pool_sig <= 1'b0;
                endcase
            end
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] r_perf_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_cycles <= '0;
        end else if (w_start_ok) begin
            r_perf_cycles <= '0;
        end else if (r_state != ST_IDLE && r_perf_cycles != 32'hFFFF_FFFF) begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
        end
    end

    assign perf_cycles = r_perf_cycles;
`endif

    assign pooling_signal       = r_pool_sig;
    assign fold_per_cols_in     = r_fold;
    assign pooling_cols         = r_poolc;
    assign pool_win_per_period  = r_win_step;
    assign pool_win_last_period = r_lastp;
    assign layer_idx            = r_layer_idx;
    assign cfg_err              = r_cfg_err;

endmodule

// File: tb/tb_cnn_layer_sched.sv
// -----------------------------------------------------------------------------
// tb_cnn_layer_sched
// Directed testbench for cnn_layer_sched: single-layer tile issue, pooling
// phase sequence, multi-layer walk with last_layer, empty layer, rejected
// busy descriptor write, abort with simultaneous tile_done and restart.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cnn_layer_sched;

    localparam int NL = 8;
    localparam int AW = 3;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          cfg_we;
    logic [AW-1:0] cfg_waddr;
    logic [31:0]   cfg_wdata;
    logic          tile_start;
    logic          tile_done;
    logic          acti_finish_flag;
    logic          pooling_signal;
    logic [3:0]    fold_per_cols_in;
    logic [3:0]    pooling_cols;
    logic [2:0]    pool_win_per_period;
    logic [3:0]    pool_win_last_period;
    logic [AW-1:0] layer_idx;
    logic          busy;
    logic          layer_done;
    logic          net_done;
    logic          cfg_err;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0]   perf_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    cnn_layer_sched #(
        .ROWS       (4),
        .COLS       (4),
        .NUM_LAYERS (NL),
        .LAYER_AW   (AW)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .abort                (abort),
        .cfg_we               (cfg_we),
        .cfg_waddr            (cfg_waddr),
        .cfg_wdata            (cfg_wdata),
        .tile_start           (tile_start),
        .tile_done            (tile_done),
        .acti_finish_flag     (acti_finish_flag),
        .pooling_signal       (pooling_signal),
        .fold_per_cols_in     (fold_per_cols_in),
        .pooling_cols         (pooling_cols),
        .pool_win_per_period  (pool_win_per_period),
        .pool_win_last_period (pool_win_last_period),
        .layer_idx            (layer_idx),
        .busy                 (busy),
        .layer_done           (layer_done),
        .net_done             (net_done),
        .cfg_err              (cfg_err)
`ifdef SCHED_PERF_CNT_EN
        ,
        .perf_cycles          (perf_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_desc(input int fold, input int poolc, input int wstep,
                                            input int lastp, input int pen, input int tiles,
                                            input int last);
        logic [31:0] d;
        d        = '0;
        d[3:0]   = fold[3:0];
        d[7:4]   = poolc[3:0];
        d[10:8]  = wstep[2:0];
        d[14:11] = lastp[3:0];
        d[15]    = pen[0];
        d[23:16] = tiles[7:0];
        d[24]    = last[0];
        return d;
    endfunction

    task automatic wr(input int idx, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_waddr = idx[AW-1:0];
        cfg_wdata = d;
        step();
        cfg_we    = 1'b0;
    endtask

    // Pulse start; returns in the first FETCH cycle (k=1).
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Run a network with tile_done held high (ignored outside WAIT), recording
    // cycle indices relative to start (k=1 is FETCH). Ends in IDLE.
    task automatic run_net(input int max_k, output int n_ld, output int first_ld,
                           output int nd_k, output int n_ts);
        n_ld = 0; first_ld = -1; nd_k = -1; n_ts = 0;
        tile_done = 1'b1;
        for (int k = 1; k <= max_k; k++) begin
            if (tile_start) n_ts++;
            if (layer_done) begin
                n_ld++;
                if (first_ld < 0) first_ld = k;
            end
            if (net_done) begin
                nd_k = k;
                break;
            end
            step();
        end
        tile_done = 1'b0;
        step();
    endtask

    initial begin
        int n_ld, first_ld, nd_k, n_ts;
        logic [3:0] ps_exp;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
        cfg_waddr = '0; cfg_wdata = '0; tile_done = 1'b0; acti_finish_flag = 1'b0;
        ps_exp = 4'b0101;

        // ---- reset state ----
        step(); step();
        $display("txn reset");
        chk("rst_busy", busy, 0);
        chk("rst_tile_start", tile_start, 0);
        chk("rst_layer_done", layer_done, 0);
        chk("rst_net_done", net_done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_pool", pooling_signal, 0);
        chk("rst_layer_idx", layer_idx, 0);
        chk("rst_fold", fold_per_cols_in, 0);
        rst_n = 1'b1;
        step();

        // ---- single layer, 2 tiles, pooling off ----
        $display("txn single_layer tiles=2 pool_en=0");
        wr(0, mk_desc(3, 2, 3, 5, 0, 2, 1));
        do_start();                                     // k=1 FETCH
        chk("t1_busy", busy, 1);
        chk("t1_idx", layer_idx, 0);
        chk("t1_ts_k1", tile_start, 0);
        step();                                         // k=2 CFG
        chk("t1_ts_k2", tile_start, 0);
        step();                                         // k=3 ISSUE
        chk("t1_ts_k3", tile_start, 1);
        chk("t1_fold", fold_per_cols_in, 3);
        chk("t1_poolc", pooling_cols, 2);
        chk("t1_step", pool_win_per_period, 3);
        chk("t1_lastp", pool_win_last_period, 5);
        step();                                         // k=4 WAIT
        chk("t1_ts_k4", tile_start, 0);
        chk("t1_pool_a", pooling_signal, 0);
        acti_finish_flag = 1'b1;
        step();                                         // k=5 WAIT
        acti_finish_flag = 1'b0;
        chk("t1_pool_b", pooling_signal, 0);
        tile_done = 1'b1;
        step();                                         // k=6 ISSUE
        tile_done = 1'b0;
        chk("t1_reissue", tile_start, 1);
        step();                                         // k=7 WAIT
        tile_done = 1'b1;
        step();                                         // k=8 LEND
        tile_done = 1'b0;
        chk("t1_layer_done", layer_done, 1);
        chk("t1_nd_early", net_done, 0);
        step();                                         // k=9 DONE
        chk("t1_net_done", net_done, 1);
        chk("t1_ld_once", layer_done, 0);
        step();
        chk("t1_idle", busy, 0);

        // ---- pooling window step 2 ----
        $display("txn pooling step=2 pulses=4");
        wr(0, mk_desc(5, 3, 2, 4, 1, 1, 1));
        do_start();
        step(); step();                                 // k=3 ISSUE
        chk("t2_step", pool_win_per_period, 2);
        step();                                         // k=4 WAIT
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_pool_%0d", i), pooling_signal, ps_exp[i]);
            acti_finish_flag = 1'b1;
            step();
            acti_finish_flag = 1'b0;
        end
        chk("t2_pool_wrap", pooling_signal, 1);
        acti_finish_flag = 1'b1;                        // same cycle as final tile_done
        tile_done = 1'b1;
        step();
        acti_finish_flag = 1'b0;
        tile_done = 1'b0;
        chk("t2_layer_done", layer_done, 1);
        chk("t2_pool_after", pooling_signal, 0);
        step(); step();
        chk("t2_idle", busy, 0);

        // ---- three layers, last_layer on layer 1 ----
        $display("txn three_layers last_on_1");
        wr(0, mk_desc(1, 1, 0, 0, 0, 1, 0));
        wr(1, mk_desc(2, 2, 0, 0, 0, 1, 1));
        wr(2, mk_desc(7, 7, 0, 0, 0, 1, 0));
        do_start();
        run_net(40, n_ld, first_ld, nd_k, n_ts);
        chk("t3_n_layer_done", n_ld, 2);
        chk("t3_first_ld_k", first_ld, 5);
        chk("t3_net_done_k", nd_k, 11);
        chk("t3_tiles", n_ts, 2);
        chk("t3_idx", layer_idx, 1);
        chk("t3_fold", fold_per_cols_in, 2);
        chk("t3_idle", busy, 0);

        // ---- empty layer ----
        $display("txn empty_layer tiles=0");
        wr(0, mk_desc(4, 0, 0, 0, 0, 0, 1));
        do_start();
        run_net(20, n_ld, first_ld, nd_k, n_ts);
        chk("t4_tiles", n_ts, 0);
        chk("t4_ld_k", first_ld, 3);
        chk("t4_nd_k", nd_k, 4);

        // ---- descriptor write while busy ----
        $display("txn cfg_we_while_busy");
        wr(0, mk_desc(9, 0, 0, 0, 0, 1, 1));
        do_start();
        step(); step(); step();                         // k=4 WAIT
        wr(0, mk_desc(4, 0, 0, 0, 0, 1, 1));
        chk("t5_cfg_err", cfg_err, 1);
        tile_done = 1'b1;
        step();
        tile_done = 1'b0;
        step(); step();
        chk("t5_err_sticky", cfg_err, 1);
        do_start();
        chk("t5_err_clr", cfg_err, 0);
        step(); step();
        chk("t5_readback", fold_per_cols_in, 9);
        run_net(20, n_ld, first_ld, nd_k, n_ts);
        chk("t5_done", busy, 0);

        // ---- abort in layer 1 WAIT with simultaneous tile_done ----
        $display("txn abort_in_wait then restart");
        wr(0, mk_desc(6, 0, 0, 0, 0, 1, 0));
        wr(1, mk_desc(8, 0, 0, 0, 0, 1, 1));
        do_start();
        tile_done = 1'b1;
        for (int k = 1; k < 8; k++) step();             // k=8 ISSUE of layer 1
        chk("t6_idx1", layer_idx, 1);
        chk("t6_issue", tile_start, 1);
        step();                                         // k=9 WAIT
        abort = 1'b1;
        step();
        abort = 1'b0;
        tile_done = 1'b0;
        chk("t6_idle", busy, 0);
        chk("t6_no_ld", layer_done, 0);
        chk("t6_idx_hold", layer_idx, 1);
        chk("t6_fold_hold", fold_per_cols_in, 8);
        step();
        chk("t6_no_ld2", layer_done, 0);
        chk("t6_no_nd", net_done, 0);
        do_start();
        chk("t6_restart_idx", layer_idx, 0);
        run_net(40, n_ld, first_ld, nd_k, n_ts);
        chk("t6_n_ld", n_ld, 2);
        chk("t6_nd_k", nd_k, 11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
